// File: rtl/red_pitaya_dfilt_pkg.sv
// Shared types and constants for the ADC equalization filter coefficient scheduler.
// Coefficient widths, register map, CTRL/STATUS bit positions and bypass reset values.
package red_pitaya_dfilt_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 32;

  localparam int AA_W = 18;
  localparam int BB_W = 25;
  localparam int KK_W = 25;
  localparam int PP_W = 25;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_SETTLE = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_AA     = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_BB     = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_KK     = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_PP     = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 3'd5;

  localparam int CTRL_PEND_BIT  = 0;
  localparam int CTRL_FLUSH_BIT = 1;

  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_VALID_BIT = 1;
  localparam int STAT_STATE_LSB = 2;

  // Bypass coefficients: filter passes data through with unity gain.
  localparam logic [AA_W-1:0] AA_BYPASS = 18'h0;
  localparam logic [BB_W-1:0] BB_BYPASS = 25'h0;
  localparam logic [KK_W-1:0] KK_BYPASS = 25'hFFFFFF;
  localparam logic [PP_W-1:0] PP_BYPASS = 25'h0;

endpackage

// File: rtl/red_pitaya_dfilt1_ctrl_if.sv
// System register bus seen by the coefficient scheduler.
// Suffixes are relative to the scheduler: _i driven by the decoder, _o returned.
interface red_pitaya_dfilt1_ctrl_if;
  import red_pitaya_dfilt_pkg::*;

  logic [ADDR_W-1:0] sys_addr_i;
  logic [DATA_W-1:0] sys_wdata_i;
  logic              sys_wen_i;
  logic              sys_ren_i;
  logic [DATA_W-1:0] sys_rdata_o;
  logic              sys_ack_o;

  modport master (
    output sys_addr_i, sys_wdata_i, sys_wen_i, sys_ren_i,
    input  sys_rdata_o, sys_ack_o
  );

  modport slave (
    input  sys_addr_i, sys_wdata_i, sys_wen_i, sys_ren_i,
    output sys_rdata_o, sys_ack_o
  );

endinterface

// File: rtl/red_pitaya_dfilt_regs.sv
// Shadow coefficient registers, CTRL flush_en bit and registered bus read/ack path.
// Commit requests leave as a single-cycle pulse; the pending flag itself lives with the FSM.
module red_pitaya_dfilt_regs
  import red_pitaya_dfilt_pkg::*;
#(
  parameter logic [AA_W-1:0] AA_RST = AA_BYPASS,
  parameter logic [BB_W-1:0] BB_RST = BB_BYPASS,
  parameter logic [KK_W-1:0] KK_RST = KK_BYPASS,
  parameter logic [PP_W-1:0] PP_RST = PP_BYPASS
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  red_pitaya_dfilt1_ctrl_if.slave bus,
  input  logic                   pending_i,
  input  state_e                 state_i,
  input  logic                   dat_valid_i,
  input  logic                   busy_i,
  output logic [AA_W-1:0]        sh_aa_o,
  output logic [BB_W-1:0]        sh_bb_o,
  output logic [KK_W-1:0]        sh_kk_o,
  output logic [PP_W-1:0]        sh_pp_o,
  output logic                   flush_en_o,
  output logic                   commit_req_o
);

  logic [AA_W-1:0]   aa_q, aa_d;
  logic [BB_W-1:0]   bb_q, bb_d;
  logic [KK_W-1:0]   kk_q, kk_d;
  logic [PP_W-1:0]   pp_q, pp_d;
  logic              flush_en_q, flush_en_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, rd_mux;
  logic              unused_wdata;

  assign unused_wdata = ^bus.sys_wdata_i[DATA_W-1:BB_W];

  always_comb begin
    aa_d       = aa_q;
    bb_d       = bb_q;
    kk_d       = kk_q;
    pp_d       = pp_q;
    flush_en_d = flush_en_q;
    if (bus.sys_wen_i) begin
      case (bus.sys_addr_i)
        ADDR_AA:   aa_d       = bus.sys_wdata_i[AA_W-1:0];
        ADDR_BB:   bb_d       = bus.sys_wdata_i[BB_W-1:0];
        ADDR_KK:   kk_d       = bus.sys_wdata_i[KK_W-1:0];
        ADDR_PP:   pp_d       = bus.sys_wdata_i[PP_W-1:0];
        ADDR_CTRL: flush_en_d = bus.sys_wdata_i[CTRL_FLUSH_BIT];
        default:   ;
      endcase
    end
  end

  assign commit_req_o = bus.sys_wen_i && (bus.sys_addr_i == ADDR_CTRL) &&
                        bus.sys_wdata_i[CTRL_PEND_BIT];

  always_comb begin
    rd_mux = '0;
    case (bus.sys_addr_i)
      ADDR_AA: rd_mux = DATA_W'(aa_q);
      ADDR_BB: rd_mux = DATA_W'(bb_q);
      ADDR_KK: rd_mux = DATA_W'(kk_q);
      ADDR_PP: rd_mux = DATA_W'(pp_q);
      ADDR_CTRL: begin
        rd_mux[CTRL_PEND_BIT]  = pending_i;
        rd_mux[CTRL_FLUSH_BIT] = flush_en_q;
      end
      ADDR_STATUS: begin
        rd_mux[STAT_BUSY_BIT]             = busy_i;
        rd_mux[STAT_VALID_BIT]            = dat_valid_i;
        rd_mux[STAT_STATE_LSB +: 2]       = state_i;
      end
      default: ;
    endcase
  end

  // Writes ack with zero data; only a read strobe returns the mux.
  assign ack_d   = bus.sys_wen_i | bus.sys_ren_i;
  assign rdata_d = bus.sys_ren_i ? rd_mux : '0;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      aa_q       <= AA_RST;
      bb_q       <= BB_RST;
      kk_q       <= KK_RST;
      pp_q       <= PP_RST;
      flush_en_q <= 1'b1;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      aa_q       <= aa_d;
      bb_q       <= bb_d;
      kk_q       <= kk_d;
      pp_q       <= pp_d;
      flush_en_q <= flush_en_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
    end
  end

  assign sh_aa_o         = aa_q;
  assign sh_bb_o         = bb_q;
  assign sh_kk_o         = kk_q;
  assign sh_pp_o         = pp_q;
  assign flush_en_o      = flush_en_q;
  assign bus.sys_ack_o   = ack_q;
  assign bus.sys_rdata_o = rdata_q;

endmodule

// File: rtl/red_pitaya_dfilt1_ctrl.sv
// Coefficient scheduler: commits shadow AA/BB/KK/PP to the filter atomically when not holding,
// optionally flushes the filter, then masks dat_valid_o until the IIR pipeline has settled.
module red_pitaya_dfilt1_ctrl
  import red_pitaya_dfilt_pkg::*;
#(
  parameter logic [AA_W-1:0] AA_RST     = AA_BYPASS,
  parameter logic [BB_W-1:0] BB_RST     = BB_BYPASS,
  parameter logic [KK_W-1:0] KK_RST     = KK_BYPASS,
  parameter logic [PP_W-1:0] PP_RST     = PP_BYPASS,
  parameter int              FLUSH_CYC  = 4,
  parameter int              SETTLE_CYC = 16
) (
  input  logic                   adc_clk_i,
  input  logic                   adc_rstn_i,
  red_pitaya_dfilt1_ctrl_if.slave bus,
  input  logic                   hold_i,
  output logic [AA_W-1:0]        cfg_aa_o,
  output logic [BB_W-1:0]        cfg_bb_o,
  output logic [KK_W-1:0]        cfg_kk_o,
  output logic [PP_W-1:0]        cfg_pp_o,
  output logic                   filt_rstn_o,
  output logic                   dat_valid_o,
  output logic                   busy_o,
  output logic                   commit_done_o
);

  localparam logic [3:0] FLUSH_LAST  = 4'(FLUSH_CYC - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

  state_e          state_q, state_d;
  logic [3:0]      flush_cnt_q, flush_cnt_d;
  logic [7:0]      settle_cnt_q, settle_cnt_d;
  logic            pending_q, pending_d;
  logic            done_q, done_d;
  logic            filt_rstn_q, dat_valid_q;
  logic            apply;
  logic            commit_req, flush_en;
  logic [AA_W-1:0] sh_aa, act_aa_q;
  logic [BB_W-1:0] sh_bb, act_bb_q;
  logic [KK_W-1:0] sh_kk, act_kk_q;
  logic [PP_W-1:0] sh_pp, act_pp_q;

  red_pitaya_dfilt_regs #(
    .AA_RST (AA_RST),
    .BB_RST (BB_RST),
    .KK_RST (KK_RST),
    .PP_RST (PP_RST)
  ) u_regs (
    .clk_i        (adc_clk_i),
    .rstn_i       (adc_rstn_i),
    .bus          (bus),
    .pending_i    (pending_q),
    .state_i      (state_q),
    .dat_valid_i  (dat_valid_q),
    .busy_i       (busy_o),
    .sh_aa_o      (sh_aa),
    .sh_bb_o      (sh_bb),
    .sh_kk_o      (sh_kk),
    .sh_pp_o      (sh_pp),
    .flush_en_o   (flush_en),
    .commit_req_o (commit_req)
  );

  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    settle_cnt_d = settle_cnt_q;
    done_d       = 1'b0;
    apply        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q && !hold_i) state_d = ST_APPLY;
      end
      ST_APPLY: begin
        apply        = 1'b1;
        flush_cnt_d  = '0;
        settle_cnt_d = '0;
        state_d      = flush_en ? ST_FLUSH : ST_SETTLE;
      end
      ST_FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) state_d = ST_SETTLE;
        else                           flush_cnt_d = flush_cnt_q + 4'd1;
      end
      ST_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          settle_cnt_d = settle_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A request landing in the APPLY cycle survives the clear so it is queued, not lost.
  assign pending_d = commit_req | (pending_q & ~apply);

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      state_q      <= ST_IDLE;
      flush_cnt_q  <= '0;
      settle_cnt_q <= '0;
      pending_q    <= 1'b0;
      done_q       <= 1'b0;
      filt_rstn_q  <= 1'b1;
      dat_valid_q  <= 1'b1;
      act_aa_q     <= AA_RST;
      act_bb_q     <= BB_RST;
      act_kk_q     <= KK_RST;
      act_pp_q     <= PP_RST;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      pending_q    <= pending_d;
      done_q       <= done_d;
      filt_rstn_q  <= (state_d != ST_FLUSH);
      dat_valid_q  <= (state_d == ST_IDLE);
      if (apply) begin
        act_aa_q <= sh_aa;
        act_bb_q <= sh_bb;
        act_kk_q <= sh_kk;
        act_pp_q <= sh_pp;
      end
    end
  end

  assign cfg_aa_o      = act_aa_q;
  assign cfg_bb_o      = act_bb_q;
  assign cfg_kk_o      = act_kk_q;
  assign cfg_pp_o      = act_pp_q;
  assign filt_rstn_o   = filt_rstn_q;
  assign dat_valid_o   = dat_valid_q;
  assign commit_done_o = done_q;
  assign busy_o        = pending_q | (state_q != ST_IDLE);

endmodule

// File: tb/tb_red_pitaya_dfilt1_ctrl.sv
// Directed bench for the coefficient scheduler with bus-read and coefficient-commit scoreboards.
module tb_red_pitaya_dfilt1_ctrl;
  import red_pitaya_dfilt_pkg::*;

  typedef struct packed {
    logic [AA_W-1:0] aa;
    logic [BB_W-1:0] bb;
    logic [KK_W-1:0] kk;
    logic [PP_W-1:0] pp;
  } coef_t;

  logic            adc_clk_i  = 1'b0;
  logic            adc_rstn_i = 1'b1;
  logic            hold_i     = 1'b0;
  logic [AA_W-1:0] cfg_aa_o;
  logic [BB_W-1:0] cfg_bb_o;
  logic [KK_W-1:0] cfg_kk_o;
  logic [PP_W-1:0] cfg_pp_o;
  logic            filt_rstn_o, dat_valid_o, busy_o, commit_done_o;

  red_pitaya_dfilt1_ctrl_if bus ();

  red_pitaya_dfilt1_ctrl dut (
    .adc_clk_i     (adc_clk_i),
    .adc_rstn_i    (adc_rstn_i),
    .bus           (bus),
    .hold_i        (hold_i),
    .cfg_aa_o      (cfg_aa_o),
    .cfg_bb_o      (cfg_bb_o),
    .cfg_kk_o      (cfg_kk_o),
    .cfg_pp_o      (cfg_pp_o),
    .filt_rstn_o   (filt_rstn_o),
    .dat_valid_o   (dat_valid_o),
    .busy_o        (busy_o),
    .commit_done_o (commit_done_o)
  );

  always #5 adc_clk_i = ~adc_clk_i;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] bus_q[$];
  coef_t       coef_q[$];
  coef_t       act_model;
  logic        cmp_next = 1'b0;
  int          ff, na, nf, ni, nd, gap;

  function automatic coef_t mk(input logic [AA_W-1:0] aa, input logic [BB_W-1:0] bb,
                               input logic [KK_W-1:0] kk, input logic [PP_W-1:0] pp);
    coef_t c;
    c.aa = aa; c.bb = bb; c.kk = kk; c.pp = pp;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_act(input string tag, input coef_t e);
    chk({tag, "_aa"}, 32'(cfg_aa_o), 32'(e.aa));
    chk({tag, "_bb"}, 32'(cfg_bb_o), 32'(e.bb));
    chk({tag, "_kk"}, 32'(cfg_kk_o), 32'(e.kk));
    chk({tag, "_pp"}, 32'(cfg_pp_o), 32'(e.pp));
  endtask

  // One bus transaction; expected read data is queued at the strobe and popped at the ack.
  task automatic bus_op(input logic wr, input logic [2:0] a, input logic [31:0] d,
                        input logic [31:0] exp, input string tag);
    logic [31:0] e;
    @(negedge adc_clk_i);
    bus.sys_addr_i  = a;
    bus.sys_wdata_i = d;
    bus.sys_wen_i   = wr;
    bus.sys_ren_i   = !wr;
    bus_q.push_back(wr ? 32'h0 : exp);
    @(negedge adc_clk_i);
    bus.sys_wen_i = 1'b0;
    bus.sys_ren_i = 1'b0;
    chk({tag, "_ack"}, 32'(bus.sys_ack_o), 32'd1);
    e = bus_q.pop_front();
    chk({tag, "_rdata"}, bus.sys_rdata_o, e);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus_op(1'b1, a, d, 32'h0, "wr");
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
    bus_op(1'b0, a, 32'h0, exp, tag);
  endtask

  // Samples ncyc negedges; a falling dat_valid_o marks APPLY, the next sample pops a commit.
  task automatic observe(input int ncyc, output int first_fall, output int n_apply,
                         output int n_flush, output int n_invalid, output int n_done,
                         output int done_gap);
    logic  prev_v;
    int    done_k;
    coef_t e;
    first_fall = -1; n_apply = 0; n_flush = 0; n_invalid = 0; n_done = 0;
    done_gap = -1; done_k = -100;
    prev_v = dat_valid_o;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge adc_clk_i);
      if (cmp_next) begin
        cmp_next = 1'b0;
        n_apply++;
        chk("apply_expected", 32'(coef_q.size() != 0), 32'd1);
        if (coef_q.size() != 0) begin
          e = coef_q.pop_front();
          chk_act("active", e);
          act_model = e;
        end
      end
      if (prev_v && !dat_valid_o) begin
        if (first_fall < 0) first_fall = k;
        if (done_k > 0) done_gap = k - done_k;
        chk_act("active_in_apply", act_model);
        cmp_next = 1'b1;
      end
      if (!filt_rstn_o)  n_flush++;
      if (!dat_valid_o)  n_invalid++;
      if (commit_done_o) begin
        n_done++;
        done_k = k;
      end
      prev_v = dat_valid_o;
    end
  endtask

  initial begin
    bus.sys_addr_i  = '0;
    bus.sys_wdata_i = '0;
    bus.sys_wen_i   = 1'b0;
    bus.sys_ren_i   = 1'b0;
    act_model = mk(18'h0, 25'h0, 25'hFFFFFF, 25'h0);

    // Asynchronous reset asserted between clock edges
    #3 adc_rstn_i = 1'b0;
    #1;
    chk_act("rst", act_model);
    chk("rst_valid", 32'(dat_valid_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_filt_rstn", 32'(filt_rstn_o), 32'd1);
    chk("rst_done", 32'(commit_done_o), 32'd0);
    chk("rst_ack", 32'(bus.sys_ack_o), 32'd0);
    chk("rst_rdata", bus.sys_rdata_o, 32'd0);
    @(negedge adc_clk_i);
    adc_rstn_i = 1'b1;
    rd(ADDR_AA, 32'h0, "rd_aa_rst");
    rd(ADDR_KK, 32'hFFFFFF, "rd_kk_rst");
    rd(ADDR_CTRL, 32'h2, "rd_ctrl_rst");
    rd(ADDR_STATUS, 32'h2, "rd_status_rst");

    // Basic commit with flush; upper write-data bits are ignored
    wr(ADDR_AA, 32'hABC1F000);
    wr(ADDR_BB, 32'h00013A7E);
    wr(ADDR_KK, 32'h00D9999A);
    wr(ADDR_PP, 32'h00002666);
    rd(ADDR_AA, 32'h0001F000, "rd_aa_shadow");
    rd(ADDR_KK, 32'h00D9999A, "rd_kk_shadow");
    chk_act("no_direct_write", act_model);
    coef_q.push_back(mk(18'h1F000, 25'h13A7E, 25'hD9999A, 25'h2666));
    wr(ADDR_CTRL, 32'h3);
    observe(30, ff, na, nf, ni, nd, gap);
    chk("basic_fall_k", 32'(ff), 32'd1);
    chk("basic_applies", 32'(na), 32'd1);
    chk("basic_flush_cyc", 32'(nf), 32'd4);
    chk("basic_invalid_cyc", 32'(ni), 32'd21);
    chk("basic_done_pulses", 32'(nd), 32'd1);
    rd(ADDR_CTRL, 32'h2, "rd_ctrl_after");
    rd(ADDR_STATUS, 32'h2, "rd_status_after");

    // Queued commit: two CTRL=1 writes plus new BB during SETTLE give one extra sequence
    coef_q.push_back(mk(18'h1F000, 25'h13A7E, 25'hD9999A, 25'h2666));
    wr(ADDR_CTRL, 32'h3);
    observe(8, ff, na, nf, ni, nd, gap);
    chk("q1_applies", 32'(na), 32'd1);
    chk("q1_flush_cyc", 32'(nf), 32'd4);
    wr(ADDR_BB, 32'h100);
    wr(ADDR_CTRL, 32'h1);
    wr(ADDR_CTRL, 32'h1);
    coef_q.push_back(mk(18'h1F000, 25'h100, 25'hD9999A, 25'h2666));
    observe(60, ff, na, nf, ni, nd, gap);
    chk("q2_done_pulses", 32'(nd), 32'd2);
    chk("q2_applies", 32'(na), 32'd1);
    chk("q2_done_to_apply", 32'(gap), 32'd1);
    chk("q2_no_flush", 32'(nf), 32'd0);
    chk("q2_drained", 32'(coef_q.size()), 32'd0);
    chk("q2_busy", 32'(busy_o), 32'd0);

    // Deferred commit under hold, then released without flush
    hold_i = 1'b1;
    wr(ADDR_PP, 32'h1ABCD);
    wr(ADDR_CTRL, 32'h1);
    observe(100, ff, na, nf, ni, nd, gap);
    chk("hold_applies", 32'(na), 32'd0);
    chk("hold_invalid", 32'(ni), 32'd0);
    chk("hold_busy", 32'(busy_o), 32'd1);
    chk_act("hold_active", act_model);
    rd(ADDR_STATUS, 32'h3, "rd_status_hold");
    rd(ADDR_CTRL, 32'h1, "rd_ctrl_hold");
    coef_q.push_back(mk(18'h1F000, 25'h100, 25'hD9999A, 25'h1ABCD));
    hold_i = 1'b0;
    observe(40, ff, na, nf, ni, nd, gap);
    chk("nf_fall_k", 32'(ff), 32'd1);
    chk("nf_applies", 32'(na), 32'd1);
    chk("nf_flush_cyc", 32'(nf), 32'd0);
    chk("nf_invalid_cyc", 32'(ni), 32'd17);
    chk("nf_done_pulses", 32'(nd), 32'd1);

    // Reset while flushing with a second commit queued
    wr(ADDR_AA, 32'h2AAAA);
    coef_q.push_back(mk(18'h2AAAA, 25'h100, 25'hD9999A, 25'h1ABCD));
    wr(ADDR_CTRL, 32'h3);
    observe(3, ff, na, nf, ni, nd, gap);
    chk("rf_applies", 32'(na), 32'd1);
    wr(ADDR_CTRL, 32'h3);
    chk("rf_in_flush", 32'(filt_rstn_o), 32'd0);
    #2 adc_rstn_i = 1'b0;
    #1;
    act_model = mk(18'h0, 25'h0, 25'hFFFFFF, 25'h0);
    cmp_next  = 1'b0;
    chk_act("rf_rst", act_model);
    chk("rf_filt_rstn", 32'(filt_rstn_o), 32'd1);
    chk("rf_busy", 32'(busy_o), 32'd0);
    chk("rf_valid", 32'(dat_valid_o), 32'd1);
    @(negedge adc_clk_i);
    adc_rstn_i = 1'b1;
    rd(ADDR_AA, 32'h0, "rf_rd_aa");
    rd(ADDR_CTRL, 32'h2, "rf_rd_ctrl");
    rd(3'd6, 32'h0, "rd_addr6");
    wr(3'd6, 32'hFFFFFFFF);
    rd(3'd6, 32'h0, "rd_addr6_after_wr");
    rd(3'd7, 32'h0, "rd_addr7");
    rd(ADDR_STATUS, 32'h2, "rf_rd_status");
    observe(30, ff, na, nf, ni, nd, gap);
    chk("rf_dropped", 32'(na), 32'd0);
    chk("rf_no_done", 32'(nd), 32'd0);
    chk("rf_idle_busy", 32'(busy_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
